// File: rtl/music_pkg.sv
// Shared types and note-word field positions for the song sequencer.
package music_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, PLAY, PAUSED} seq_state_t;

  localparam int DUR_MSB = 15;
  localparam int DUR_LSB = 12;
  localparam int PER_MSB = 11;
  localparam int PER_LSB = 0;

  localparam logic [3:0]  END_DUR = 4'd0;
  localparam logic [15:0] SILENCE = 16'd0;

endpackage

// File: rtl/music_beat_counter.sv
// Remaining-beats counter for the current note; it never decrements below one,
// so the sequencer can see the final beat and decide what happens on its tick.
import music_pkg::*;

module music_beat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       tick,
  output logic       last_beat
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count > 4'd1)) begin
      count <= count - 4'd1;
    end
  end

  assign last_beat = (count == 4'd1);

endmodule

// File: rtl/music_seq_ctrl.sv
// Song sequencer: walks the song memory, loads each note period into the
// external period register and times it in beats, with pause/resume and stop.
import music_pkg::*;

module music_seq_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              beat_tick,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              reg_en,
  output logic [15:0]       reg_d,
  output logic              playing,
  output logic              paused,
  output logic              done
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  seq_state_t        state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [11:0]       cur_period;
  logic [3:0]        note_dur;
  logic [11:0]       note_period;
  logic              cnt_load, cnt_clear, cnt_tick, last_beat;

  assign note_dur    = mem_rdata[DUR_MSB:DUR_LSB];
  assign note_period = mem_rdata[PER_MSB:PER_LSB];
  assign mem_addr    = ptr;

  // Load strobes are combinational so the register sees them in the deciding cycle.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    reg_en    = 1'b0;
    reg_d     = SILENCE;
    done      = 1'b0;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_tick  = 1'b0;
    if (!rst) begin
      if (stop && (state != IDLE)) begin
        reg_en    = 1'b1;
        ptr_n     = '0;
        cnt_clear = 1'b1;
        state_n   = IDLE;
      end else begin
        case (state)
          IDLE:   if (play) state_n = FETCH;
          FETCH:  state_n = DECODE;
          DECODE: begin
            reg_en = 1'b1;
            if (note_dur == END_DUR) begin
              done    = 1'b1;
              ptr_n   = '0;
              state_n = IDLE;
            end else begin
              reg_d    = {4'b0000, note_period};
              cnt_load = 1'b1;
              state_n  = PLAY;
            end
          end
          PLAY: begin
            if (pause) begin
              reg_en  = 1'b1;
              state_n = PAUSED;
            end else if (beat_tick) begin
              if (!last_beat) begin
                cnt_tick = 1'b1;
              end else if (ptr != PTR_LAST) begin
                ptr_n   = ptr + 1'b1;
                state_n = FETCH;
              end else begin
                reg_en  = 1'b1;
                done    = 1'b1;
                ptr_n   = '0;
                state_n = IDLE;
              end
            end
          end
          PAUSED: begin
            if (play) begin
              reg_en  = 1'b1;
              reg_d   = {4'b0000, cur_period};
              state_n = PLAY;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Status flags are registered from the next state so they track the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cur_period <= 12'd0;
      playing    <= 1'b0;
      paused     <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      playing <= (state_n == FETCH) || (state_n == DECODE) || (state_n == PLAY);
      paused  <= (state_n == PAUSED);
      if (cnt_load) cur_period <= note_period;
    end
  end

  music_beat_counter u_beats (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .load      (cnt_load),
    .load_val  (note_dur),
    .tick      (cnt_tick),
    .last_beat (last_beat)
  );

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed bench for music_seq_ctrl: a cycle table for a full song plus
// hand-written pause, stop, end-of-memory, simultaneous-event and reset sequences.
module tb_music_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, play, pause, stop, beat_tick;
  logic [5:0]  addr1;
  logic [1:0]  addr2;
  logic [15:0] rdata1, rdata2, d1, d2, q1, q2;
  logic        en1, en2, playing1, playing2, paused1, paused2, done1, done2;
  logic [15:0] rom1 [64];
  logic [15:0] rom2 [4];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  music_seq_ctrl #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .beat_tick(beat_tick), .mem_addr(addr1), .mem_rdata(rdata1),
    .reg_en(en1), .reg_d(d1), .playing(playing1), .paused(paused1), .done(done1)
  );

  music_seq_ctrl #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .beat_tick(beat_tick), .mem_addr(addr2), .mem_rdata(rdata2),
    .reg_en(en2), .reg_d(d2), .playing(playing2), .paused(paused2), .done(done2)
  );

  // Synchronous song ROMs and the period registers fed by the sequencers.
  always_ff @(posedge clk) begin
    rdata1 <= rom1[addr1];
    rdata2 <= rom2[addr2];
    if (rst) q1 <= 16'h0; else if (en1) q1 <= d1;
    if (rst) q2 <= 16'h0; else if (en2) q2 <= d2;
  end

  typedef struct {
    logic [3:0]  stim;   // {play, pause, stop, beat_tick}
    logic [3:0]  flags;  // {reg_en, done, playing, paused}
    logic [15:0] d;
    logic [5:0]  addr;
    logic [15:0] q;
  } vec_t;

  vec_t tbl [17];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic pa, input logic s, input logic t);
    play = p; pause = pa; stop = s; beat_tick = t;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    play = 1'b0; pause = 1'b0; stop = 1'b0; beat_tick = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clearRoms();
    for (int i = 0; i < 64; i++) rom1[i] = 16'h0000;
    for (int i = 0; i < 4; i++) rom2[i] = 16'h0000;
  endtask

  initial begin
    rst = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; beat_tick = 1'b0;
    clearRoms();
    @(posedge clk);
    #1;
    checkOutput("reset.reg_en", 16'(en1), 16'h0);
    checkOutput("reset.reg_d", d1, 16'h0);
    checkOutput("reset.playing", 16'(playing1), 16'h0);
    checkOutput("reset.paused", 16'(paused1), 16'h0);
    checkOutput("reset.done", 16'(done1), 16'h0);
    checkOutput("reset.mem_addr", 16'(addr1), 16'h0);

    // Basic play, with play-in-PLAY, pause-in-FETCH and stop-in-IDLE ignored.
    rom1[0] = 16'h2123; rom1[1] = 16'h1456; rom1[2] = 16'h0000;
    tbl[0]  = '{4'b1000, 4'b0000, 16'h0000, 6'd0, 16'h0000};
    tbl[1]  = '{4'b0100, 4'b0010, 16'h0000, 6'd0, 16'h0000};
    tbl[2]  = '{4'b0000, 4'b1010, 16'h0123, 6'd0, 16'h0000};
    tbl[3]  = '{4'b0000, 4'b0010, 16'h0000, 6'd0, 16'h0123};
    tbl[4]  = '{4'b0001, 4'b0010, 16'h0000, 6'd0, 16'h0123};
    tbl[5]  = '{4'b1000, 4'b0010, 16'h0000, 6'd0, 16'h0123};
    tbl[6]  = '{4'b0000, 4'b0010, 16'h0000, 6'd0, 16'h0123};
    tbl[7]  = '{4'b0000, 4'b0010, 16'h0000, 6'd0, 16'h0123};
    tbl[8]  = '{4'b0001, 4'b0010, 16'h0000, 6'd0, 16'h0123};
    tbl[9]  = '{4'b0100, 4'b0010, 16'h0000, 6'd1, 16'h0123};
    tbl[10] = '{4'b0000, 4'b1010, 16'h0456, 6'd1, 16'h0123};
    tbl[11] = '{4'b0000, 4'b0010, 16'h0000, 6'd1, 16'h0456};
    tbl[12] = '{4'b0001, 4'b0010, 16'h0000, 6'd1, 16'h0456};
    tbl[13] = '{4'b0000, 4'b0010, 16'h0000, 6'd2, 16'h0456};
    tbl[14] = '{4'b0000, 4'b1110, 16'h0000, 6'd2, 16'h0456};
    tbl[15] = '{4'b0010, 4'b0000, 16'h0000, 6'd0, 16'h0000};
    tbl[16] = '{4'b0000, 4'b0000, 16'h0000, 6'd0, 16'h0000};
    doReset();
    for (int r = 0; r < 17; r++) begin
      applyStimulus(tbl[r].stim[3], tbl[r].stim[2], tbl[r].stim[1], tbl[r].stim[0]);
      checkOutput($sformatf("row%0d.reg_en", r), 16'(en1), 16'(tbl[r].flags[3]));
      checkOutput($sformatf("row%0d.done", r), 16'(done1), 16'(tbl[r].flags[2]));
      checkOutput($sformatf("row%0d.playing", r), 16'(playing1), 16'(tbl[r].flags[1]));
      checkOutput($sformatf("row%0d.paused", r), 16'(paused1), 16'(tbl[r].flags[0]));
      checkOutput($sformatf("row%0d.reg_d", r), d1, tbl[r].d);
      checkOutput($sformatf("row%0d.mem_addr", r), 16'(addr1), 16'(tbl[r].addr));
      checkOutput($sformatf("row%0d.q", r), q1, tbl[r].q);
      nextCycle();
    end

    // Pause and resume with beat_tick ignored while paused.
    clearRoms();
    rom1[0] = 16'h3ABC;
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("pr.q_first", q1, 16'h0ABC);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("pr.pause_en", 16'(en1), 16'h1);
    checkOutput("pr.pause_d", d1, 16'h0);
    nextCycle();
    checkOutput("pr.paused", 16'(paused1), 16'h1);
    checkOutput("pr.playing", 16'(playing1), 16'h0);
    checkOutput("pr.q_muted", q1, 16'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("pr.tick%0d_en", i), 16'(en1), 16'h0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pr.resume_d", d1, 16'h0ABC);
    nextCycle();
    checkOutput("pr.q_resumed", q1, 16'h0ABC);
    checkOutput("pr.playing2", 16'(playing1), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); nextCycle();
    checkOutput("pr.after_tick1_addr", 16'(addr1), 16'h0);
    checkOutput("pr.after_tick1_playing", 16'(playing1), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); nextCycle();
    checkOutput("pr.after_tick2_addr", 16'(addr1), 16'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pr.end_done", 16'(done1), 16'h1);
    nextCycle();
    checkOutput("pr.end_q", q1, 16'h0);
    checkOutput("pr.end_playing", 16'(playing1), 16'h0);

    // Stop mid-song, replay from the top, then stop together with pause.
    clearRoms();
    rom1[0] = 16'hF111; rom1[1] = 16'hF222;
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); nextCycle();
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("stop.en", 16'(en1), 16'h1);
    checkOutput("stop.d", d1, 16'h0);
    checkOutput("stop.done", 16'(done1), 16'h0);
    nextCycle();
    checkOutput("stop.q", q1, 16'h0);
    checkOutput("stop.playing", 16'(playing1), 16'h0);
    checkOutput("stop.paused", 16'(paused1), 16'h0);
    checkOutput("stop.addr", 16'(addr1), 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("replay.d", d1, 16'h0111);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("stoppause.en", 16'(en1), 16'h1);
    checkOutput("stoppause.d", d1, 16'h0);
    nextCycle();
    checkOutput("stoppause.paused", 16'(paused1), 16'h0);
    checkOutput("stoppause.playing", 16'(playing1), 16'h0);

    // Pause arriving with the final beat keeps that beat pending.
    clearRoms();
    rom1[0] = 16'h1555;
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); nextCycle();
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("pt.en", 16'(en1), 16'h1);
    checkOutput("pt.d", d1, 16'h0);
    nextCycle();
    checkOutput("pt.paused", 16'(paused1), 16'h1);
    checkOutput("pt.addr", 16'(addr1), 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pt.resume_d", d1, 16'h0555);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); nextCycle();
    checkOutput("pt.next_addr", 16'(addr1), 16'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pt.end_done", 16'(done1), 16'h1);
    nextCycle();

    // End of memory on the 4-word instance: no marker, wrap to IDLE after note 3.
    clearRoms();
    rom2[0] = 16'h1001; rom2[1] = 16'h1002; rom2[2] = 16'h1003; rom2[3] = 16'h1004;
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); nextCycle();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("eom%0d.addr", i), 16'(addr2), 16'(i));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("eom%0d.en", i), 16'(en2), 16'h1);
      checkOutput($sformatf("eom%0d.d", i), d2, 16'(i + 1));
      nextCycle();
      checkOutput($sformatf("eom%0d.q", i), q2, 16'(i + 1));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("eom%0d.done", i), 16'(done2), (i == 3) ? 16'h1 : 16'h0);
      checkOutput($sformatf("eom%0d.tick_en", i), 16'(en2), (i == 3) ? 16'h1 : 16'h0);
      nextCycle();
    end
    checkOutput("eom.final_addr", 16'(addr2), 16'h0);
    checkOutput("eom.final_playing", 16'(playing2), 16'h0);
    checkOutput("eom.final_q", q2, 16'h0);

    // Reset while a note is sounding.
    clearRoms();
    rom1[0] = 16'h5777;
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("rst.q_before", q1, 16'h0777);
    rst = 1'b1;
    #1;
    checkOutput("rst.en_during", 16'(en1), 16'h0);
    @(posedge clk);
    #1;
    checkOutput("rst.en_after", 16'(en1), 16'h0);
    checkOutput("rst.playing", 16'(playing1), 16'h0);
    checkOutput("rst.addr", 16'(addr1), 16'h0);
    checkOutput("rst.q", q1, 16'h0);
    rst = 1'b0;
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/music_seq_ctrl.md
Name: music_seq_ctrl

Overview:
Song sequencer for the music player. It walks a song memory of packed note words. For each note it loads a 16-bit tone-period register through that register's en/d inputs, then holds the note for a programmed number of beats. It supports play, pause/resume and stop, and sits between the song ROM, the beat-tick generator and the period register that feeds the tone generator.

Parameters:
ADDR_W, 6, song memory address width; song depth = 2**ADDR_W words

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
play  in  1  start from IDLE / resume from PAUSED (level, sampled each cycle)
pause  in  1  pause while PLAY
stop  in  1  abort playback, return to IDLE
beat_tick  in  1  one-cycle pulse per beat
mem_addr  out  ADDR_W  song memory read address (= note pointer)
mem_rdata  in  16  song word, valid the cycle after mem_addr is presented; {dur[15:12], period[11:0]}
reg_en  out  1  load enable to the period register
reg_d  out  16  load data to the period register; 0 = silence
playing  out  1  high in FETCH, DECODE and PLAY
paused  out  1  high in PAUSED
done  out  1  one-cycle pulse when the song ends (marker or end of memory)

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, ptr=0, beat_cnt=0, cur_period=0.
  - Outputs during and after reset: reg_en=0, reg_d=0, playing=0, paused=0, done=0, mem_addr=0.
- States: IDLE, FETCH, DECODE, PLAY, PAUSED.
- mem_addr = ptr (registered) in all states.
- IDLE: play -> FETCH. Other inputs are ignored.
- FETCH: one cycle, address presented -> DECODE.
- DECODE (mem_rdata valid):
  - dur==0 (end marker): reg_en=1, reg_d=0, done=1, ptr<=0 -> IDLE.
  - dur!=0: reg_en=1, reg_d={4'b0,period}, cur_period<=period, beat_cnt<=dur -> PLAY.
  - period==0 is a rest: the note is loaded and timed normally.
- PLAY, on beat_tick:
  - beat_cnt>1: decrement.
  - beat_cnt==1 and ptr!=2**ADDR_W-1: ptr<=ptr+1 -> FETCH.
  - beat_cnt==1 and ptr==2**ADDR_W-1 (end of memory): reg_en=1, reg_d=0, done=1, ptr<=0 -> IDLE.
- PLAY, on pause: reg_en=1, reg_d=0 (mute), beat_cnt held -> PAUSED.
- PAUSED: play -> reg_en=1, reg_d={4'b0,cur_period} -> PLAY, remaining beats unchanged. beat_tick is ignored.
- stop, in any state except IDLE: reg_en=1, reg_d=0, ptr<=0, beat_cnt<=0 -> IDLE, done stays 0. stop in IDLE is a no-op.
- Priority in the same cycle: rst > stop > pause > beat_tick > play.
  - pause together with the final beat_tick: the pause wins and the tick is lost (beat_cnt stays 1).
  - play while PLAY, FETCH or DECODE: ignored. pause outside PLAY: ignored.
- reg_en and reg_d are combinational from state, inputs and mem_rdata.
  - reg_en is asserted only in the cases listed above, otherwise reg_en=0 and reg_d=0.
  - The period register therefore shows the new value one cycle after reg_en.
- Latency: play sampled in IDLE at cycle 0 -> FETCH at cycle 1 -> DECODE load at cycle 2 -> period register q valid at cycle 3.
- Stall between notes: 2 cycles (FETCH + DECODE) after the final beat_tick.

Decomposition:
- Package music_pkg holds:
  - typedef enum seq_state_t {IDLE, FETCH, DECODE, PLAY, PAUSED}
  - DUR_MSB=15, DUR_LSB=12, PER_MSB=11, PER_LSB=0
  - END_DUR=4'd0, SILENCE=16'd0
- One sub-module, music_beat_counter:
  - 4-bit down-counter with load and decrement-on-tick.
  - Outputs last_beat (count==1).
- FSM and pointer stay in music_seq_ctrl.
- The bench instantiates the existing 16-bit period register with rst=rst, en=reg_en, d=reg_d.

Test Plan:
- Basic play: ROM {0x2123, 0x1456, 0x0000}, pulse play, beat_tick every 4 cycles -> register q=0x0123 at cycle 3, held for 2 ticks, then q=0x0456 for 1 tick, then q=0x0000 with done pulse; mem_addr returns to 0, playing=0.
- Pause/resume: ROM {0x3ABC, 0x0000}; pause after 1 tick -> q=0x0000, paused=1; send 5 beat_ticks, no change; play -> q=0x0ABC, exactly 2 more ticks before the end.
- Stop mid-song: ROM {0xF111, 0xF222}; stop during note 0 -> q=0, state IDLE, mem_addr=0, done=0; replay restarts at 0x0111.
- End of memory: ADDR_W=2, ROM {0x1001, 0x1002, 0x1003, 0x1004} with no marker -> four notes play in order, then q=0, done pulses, mem_addr=0.
- Simultaneous events: pause with the final beat_tick -> PAUSED with the same note still pending. stop with pause -> IDLE. play in PLAY -> no effect.
- Reset mid-note: rst=1 during PLAY with q=0x0777 -> next cycle reg_en=0, playing=0, mem_addr=0, register q=0.
